// File: rtl/rv32i_io_pkg.sv
// Shared constants and types for the RV32I memory-mapped I/O responder.
// Register word offsets, STATUS bit positions, TX FIFO depth and UART FSM states.
package rv32i_io_pkg;

  localparam logic [28:0] AddrGpioOut = 29'd0;
  localparam logic [28:0] AddrGpioIn  = 29'd1;
  localparam logic [28:0] AddrTxData  = 29'd2;
  localparam logic [28:0] AddrStatus  = 29'd3;
  localparam logic [28:0] AddrTimer   = 29'd4;

  localparam int unsigned StatFull  = 0;
  localparam int unsigned StatEmpty = 1;
  localparam int unsigned StatBusy  = 2;
  localparam int unsigned StatOvf   = 3;
  localparam int unsigned StatCntLo = 4;

  localparam int unsigned FifoDepth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/rv32i_uart_tx.sv
// 8N1 UART serializer; accepts a byte whenever o_ready is high and i_valid is set.
// Ready is raised in IDLE and on the last STOP cycle so frames can run back to back.
module rv32i_uart_tx
  import rv32i_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int unsigned   CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  uart_state_e     r_state, w_state_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic [2:0]      r_bit, w_bit_next;
  logic [7:0]      r_shift, w_shift_next;
  logic            w_bit_end;

  assign w_bit_end = (r_cnt == CntLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    o_ready      = 1'b0;
    case (r_state)
      StIdle: begin
        o_ready    = 1'b1;
        w_cnt_next = '0;
        if (i_valid) begin
          w_state_next = StStart;
          w_shift_next = i_byte;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_next = StData;
          w_cnt_next   = '0;
          w_bit_next   = '0;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          w_bit_next   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_next = StStop;
        end
      end
      StStop: begin
        if (w_bit_end) begin
          o_ready      = 1'b1;
          w_cnt_next   = '0;
          // Chain straight into the next START when a byte is waiting.
          if (i_valid) begin
            w_state_next = StStart;
            w_shift_next = i_byte;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_busy = (r_state != StIdle);
  assign o_tx   = (r_state == StStart) ? 1'b0 :
                  (r_state == StData)  ? r_shift[0] : 1'b1;

endmodule

// File: rtl/rv32i_io_responder.sv
// Memory-mapped I/O block: GPIO out/in, 4-entry UART TX FIFO, STATUS and free-running TIMER.
// Read data is captured every cycle from the current address and has no side effects.
module rv32i_io_responder
  import rv32i_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned GPIO_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:2]       io_addr,
  input  logic              io_we,
  input  logic [31:0]       io_wdata,
  output logic [31:0]       io_rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              uart_tx
);

  logic [28:0]       w_word;
  logic              w_unused_addr;
  logic [31:0]       r_rdata, w_rdata, w_status;
  logic [GPIO_W-1:0] r_gpio_out, r_sync1, r_sync2;
  logic [31:0]       r_timer;
  logic [7:0]        r_fifo [FifoDepth];
  logic [1:0]        r_wptr, r_rptr;
  logic [2:0]        r_count;
  logic              r_ovf;
  logic              w_full, w_empty, w_wr_tx, w_push, w_pop, w_ovf_evt, w_ovf_clr;
  logic              w_tx_ready, w_tx_busy;

  // Only bits [30:2] take part in decode.
  assign w_word        = io_addr[30:2];
  assign w_unused_addr = io_addr[31];

  assign w_full    = (r_count == 3'(FifoDepth));
  assign w_empty   = (r_count == 3'd0);
  assign w_wr_tx   = io_we && (w_word == AddrTxData);
  assign w_push    = w_wr_tx && !w_full;
  assign w_ovf_evt = w_wr_tx && w_full;
  assign w_ovf_clr = io_we && (w_word == AddrStatus) && io_wdata[StatOvf];
  assign w_pop     = w_tx_ready && !w_empty;

  always_comb begin
    w_status                    = '0;
    w_status[StatFull]          = w_full;
    w_status[StatEmpty]         = w_empty;
    w_status[StatBusy]          = w_tx_busy;
    w_status[StatOvf]           = r_ovf;
    w_status[StatCntLo +: 3]    = r_count;
  end

  always_comb begin
    w_rdata = '0;
    case (w_word)
      AddrGpioOut: w_rdata = 32'(r_gpio_out);
      AddrGpioIn:  w_rdata = 32'(r_sync2);
      AddrStatus:  w_rdata = w_status;
      AddrTimer:   w_rdata = r_timer;
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata    <= '0;
      r_gpio_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_timer    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < int'(FifoDepth); i++) r_fifo[i] <= '0;
    end else begin
      r_rdata <= w_rdata;
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (io_we && (w_word == AddrGpioOut)) r_gpio_out <= io_wdata[GPIO_W-1:0];
      if (io_we && (w_word == AddrTimer)) r_timer <= io_wdata;
      else                                r_timer <= r_timer + 32'd1;
      if (w_push) begin
        r_fifo[r_wptr] <= io_wdata[7:0];
        r_wptr         <= r_wptr + 2'd1;
      end
      if (w_pop) r_rptr <= r_rptr + 2'd1;
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_push) r_count <= r_count - 3'd1;
      // A dropped push outranks a same-cycle clear.
      if (w_ovf_evt)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign io_rdata = r_rdata;
  assign gpio_out = r_gpio_out;

  rv32i_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk    (clk),
    .reset_n(reset_n),
    .i_byte (r_fifo[r_rptr]),
    .i_valid(!w_empty),
    .o_ready(w_tx_ready),
    .o_busy (w_tx_busy),
    .o_tx   (uart_tx)
  );

endmodule

// File: tb/tb_rv32i_io_responder.sv
// Self-checking bench for rv32i_io_responder: directed vector table, UART/FIFO/reset
// sequences, then randomized traffic against a frame-position reference model.
module tb_rv32i_io_responder;

  localparam int CPB   = 4;
  localparam int GW    = 16;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:2]   io_addr = '0;
  logic          io_we = 1'b0;
  logic [31:0]   io_wdata = '0;
  logic [31:0]   io_rdata;
  logic [GW-1:0] gpio_in = '0;
  logic [GW-1:0] gpio_out;
  logic          uart_tx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32i_io_responder #(
    .CLKS_PER_BIT(CPB),
    .GPIO_W      (GW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io_addr (io_addr),
    .io_we   (io_we),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .uart_tx (uart_tx)
  );

  // Reference model: a byte queue plus the position (0..FRAME-1) inside the current frame.
  logic [GW-1:0] m_gpio_out, m_s1, m_s2;
  logic [31:0]   m_timer, m_rdata;
  logic [7:0]    m_q[$];
  logic [7:0]    m_byte;
  bit            m_ovf, m_active;
  int            m_pos;

  typedef struct {
    int unsigned word;
    bit          we;
    logic [31:0] wd;
    logic [15:0] gin;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_gpio;
  } vec_t;

  vec_t tbl[14];
  logic tx_pat[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_gpio_out = '0; m_s1 = '0; m_s2 = '0; m_timer = '0; m_rdata = '0;
    m_q.delete(); m_byte = '0; m_ovf = 0; m_active = 0; m_pos = 0;
  endtask

  function automatic logic m_tx_exp();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [28:0] a);
    logic [31:0] s;
    s = '0;
    case (a)
      29'd0: return 32'(m_gpio_out);
      29'd1: return 32'(m_s2);
      29'd3: begin
        s[0]   = (m_q.size() == 4);
        s[1]   = (m_q.size() == 0);
        s[2]   = m_active;
        s[3]   = m_ovf;
        s[6:4] = 3'(m_q.size());
        return s;
      end
      29'd4: return m_timer;
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic m_step();
    logic [28:0] a;
    bit full_b, pop, wr_tx;
    a      = io_addr[30:2];
    m_rdata = m_read(a);
    full_b = (m_q.size() == 4);
    pop    = (!m_active || m_pos == FRAME - 1) && (m_q.size() != 0);
    wr_tx  = io_we && (a == 29'd2);
    if (m_active && m_pos != FRAME - 1) m_pos++;
    else if (pop) begin
      m_byte = m_q.pop_front(); m_active = 1; m_pos = 0;
    end else m_active = 0;
    if (wr_tx) begin
      if (full_b) m_ovf = 1;
      else m_q.push_back(io_wdata[7:0]);
    end else if (io_we && a == 29'd3 && io_wdata[3]) m_ovf = 0;
    if (io_we && a == 29'd0) m_gpio_out = io_wdata[GW-1:0];
    m_timer = (io_we && a == 29'd4) ? io_wdata : m_timer + 32'd1;
    m_s2 = m_s1;
    m_s1 = gpio_in;
  endtask

  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
    chk("rdata", io_rdata, m_rdata);
    chk("gpio_out", 32'(gpio_out), 32'(m_gpio_out));
    chk("uart_tx", 32'(uart_tx), 32'(m_tx_exp()));
  endtask

  task automatic drive(input int unsigned word, input bit we, input logic [31:0] wd);
    io_addr  = word[29:0];
    io_we    = we;
    io_wdata = wd;
    cycle();
  endtask

  // Called at posedge+1; asserts reset between edges and releases it two edges later.
  task automatic pulse_reset();
    io_we   = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_uart_tx", 32'(uart_tx), 32'h1);
    chk("rst_rdata", io_rdata, 32'h0);
    chk("rst_gpio_out", 32'(gpio_out), 32'h0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{0,      1, 32'h0000A5A5, 16'h0, 1, 32'h0,        16'hA5A5};
    tbl[1]  = '{0,      0, 32'h0,        16'h0, 1, 32'h0000A5A5, 16'hA5A5};
    tbl[2]  = '{1,      0, 32'h0,        16'h3, 1, 32'h0,        16'hA5A5};
    tbl[3]  = '{1,      0, 32'h0,        16'h3, 1, 32'h0,        16'hA5A5};
    tbl[4]  = '{1,      0, 32'h0,        16'h3, 1, 32'h3,        16'hA5A5};
    tbl[5]  = '{2,      0, 32'h0,        16'h3, 1, 32'h0,        16'hA5A5};
    tbl[6]  = '{3,      0, 32'h0,        16'h3, 1, 32'h2,        16'hA5A5};
    tbl[7]  = '{4,      1, 32'hFFFFFFFE, 16'h3, 0, 32'h0,        16'hA5A5};
    tbl[8]  = '{4,      0, 32'h0,        16'h3, 1, 32'hFFFFFFFE, 16'hA5A5};
    tbl[9]  = '{4,      0, 32'h0,        16'h3, 1, 32'hFFFFFFFF, 16'hA5A5};
    tbl[10] = '{4,      0, 32'h0,        16'h3, 1, 32'h0,        16'hA5A5};
    tbl[11] = '{5,      1, 32'h1234,     16'h3, 1, 32'h0,        16'hA5A5};
    tbl[12] = '{0,      0, 32'h0,        16'h3, 1, 32'h0000A5A5, 16'hA5A5};
    tbl[13] = '{32'h1000, 0, 32'h0,      16'h3, 1, 32'h0,        16'hA5A5};
    // 0x55 framed: start, LSB-first data, stop.
    tx_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    m_reset();
    #1;
    chk("por_uart_tx", 32'(uart_tx), 32'h1);
    chk("por_rdata", io_rdata, 32'h0);
    chk("por_gpio_out", 32'(gpio_out), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      gpio_in = tbl[i].gin;
      drive(tbl[i].word, tbl[i].we, tbl[i].wd);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), io_rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_gpio", i), 32'(gpio_out), 32'(tbl[i].exp_gpio));
    end

    // Single frame of 0x55 while watching STATUS.
    drive(2, 1, 32'h55);
    for (int k = 0; k < FRAME; k++) begin
      drive(3, 0, 32'h0);
      chk($sformatf("frame_bit%0d", k), 32'(uart_tx), 32'(tx_pat[k / CPB]));
      if (k >= 1) chk("frame_busy", 32'(io_rdata[2]), 32'h1);
    end
    drive(3, 0, 32'h0);
    drive(3, 0, 32'h0);
    chk("frame_done_status", io_rdata, 32'h2);

    // Reset in the middle of a DATA bit while the line is low, with a byte still queued.
    drive(2, 1, 32'h00);
    drive(2, 1, 32'h11);
    repeat (8) drive(0, 0, 32'h0);
    chk("mid_data_low", 32'(uart_tx), 32'h0);
    pulse_reset();
    drive(3, 0, 32'h0);
    drive(3, 0, 32'h0);
    chk("post_reset_status", io_rdata, 32'h2);

    // Six back-to-back pushes: one popped at once, four queued, one dropped.
    for (int i = 0; i < 6; i++) drive(2, 1, 32'h10 + 32'(i));
    drive(3, 0, 32'h0);
    chk("ovf_status", io_rdata, 32'h4D);
    drive(3, 1, 32'h8);
    drive(3, 0, 32'h0);
    chk("ovf_cleared", io_rdata, 32'h45);

    for (int i = 0; i < 2500; i++) begin
      int unsigned w;
      w = ($urandom_range(0, 99) < 90) ? $urandom_range(0, 5) : $urandom;
      if ($urandom_range(0, 3) == 0) gpio_in = GW'($urandom);
      drive(w, $urandom_range(0, 2) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
